// File: rtl/bfp_krnl_feeder_if.sv
// Stream-side, bias and kernel-side signals of the kernel feeder.
// master = feeder, slave = surrounding buffers/kernel.
interface bfp_krnl_feeder_if #(
   parameter int PC            = 64,
   parameter int IN_DATA_WIDTH = 8
);
   localparam int DW = PC * IN_DATA_WIDTH;

   logic          act_vld;
   logic          act_rdy;
   logic [DW-1:0] act_dat;
   logic          wgt_vld;
   logic          wgt_rdy;
   logic [DW-1:0] wgt_dat;
   logic          bin_vld;
   logic          bin_rdy;
   logic [31:0]   bin_dat;
   logic          up_vld;
   logic          coef_vld;
   logic [DW-1:0] up_dat;
   logic [DW-1:0] coef;
   logic          up_rdy;
   logic          acc_result_vld;
   logic          filter_finish_data;
   logic          filter_finish_cal;
   logic [31:0]   bias_dat;
   logic          bias_vld;

   modport master (
      input  act_vld, act_dat, wgt_vld, wgt_dat, bin_vld, bin_dat, up_rdy, filter_finish_cal,
      output act_rdy, wgt_rdy, bin_rdy, up_vld, coef_vld, up_dat, coef, acc_result_vld,
             filter_finish_data, bias_dat, bias_vld
   );

   modport slave (
      output act_vld, act_dat, wgt_vld, wgt_dat, bin_vld, bin_dat, up_rdy, filter_finish_cal,
      input  act_rdy, wgt_rdy, bin_rdy, up_vld, coef_vld, up_dat, coef, acc_result_vld,
             filter_finish_data, bias_dat, bias_vld
   );
endinterface

// File: rtl/bfp_krnl_feeder.sv
// Pairs activation/weight vectors into a one-entry slot for the compute kernel, tags
// pixel/filter boundaries and sequences one bias word per filter.
module bfp_krnl_feeder #(
   parameter int PC            = 64,
   parameter int IN_DATA_WIDTH = 8,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_start,
   input  logic [CNT_W-1:0] cfg_taps,
   input  logic [CNT_W-1:0] cfg_pixels,
   input  logic [CNT_W-1:0] cfg_filters,
   input  logic [4:0]       cfg_shift,
   output logic [4:0]       shift_bits,
   output logic             busy,
   output logic             done,
   bfp_krnl_feeder_if.master bus
);
   localparam int DW = PC * IN_DATA_WIDTH;
   localparam int TW = 2 * CNT_W;

   typedef enum logic [2:0] {S_IDLE, S_BIAS, S_STREAM, S_FIN, S_WAIT, S_DONE} state_t;

   state_t           state_q;
   logic [CNT_W-1:0] taps_q, pixels_q, filters_q;
   logic [CNT_W-1:0] tap_cnt_q, pix_cnt_q, flt_cnt_q;
   logic [TW-1:0]    total_q, issued_q;
   logic             slot_full_q;
   logic [DW-1:0]    act_q, wgt_q;
   logic [31:0]      bias_q;
   logic             bias_vld_q, fin_q, done_q, busy_q;
   logic [4:0]       shift_q;

   logic load, xfer, last_tap, last_pix, last_flt, cfg_zero;

   // up_rdy only gates draining and refilling the slot, never up_vld itself
   always_comb begin
      xfer     = slot_full_q & bus.up_rdy;
      last_tap = (tap_cnt_q == taps_q - CNT_W'(1));
      last_pix = (pix_cnt_q == pixels_q - CNT_W'(1));
      last_flt = (flt_cnt_q == filters_q - CNT_W'(1));
      cfg_zero = (cfg_taps == '0) | (cfg_pixels == '0) | (cfg_filters == '0);
      load     = (state_q == S_STREAM) & bus.act_vld & bus.wgt_vld
               & (~slot_full_q | bus.up_rdy) & (issued_q < total_q);

      bus.act_rdy            = load;
      bus.wgt_rdy            = load;
      bus.bin_rdy            = (state_q == S_BIAS);
      bus.up_vld             = slot_full_q;
      bus.coef_vld           = slot_full_q;
      bus.up_dat             = act_q;
      bus.coef               = wgt_q;
      bus.acc_result_vld     = slot_full_q & last_tap;
      bus.filter_finish_data = fin_q;
      bus.bias_dat           = bias_q;
      bus.bias_vld           = bias_vld_q;
      shift_bits             = shift_q;
      busy                   = busy_q;
      done                   = done_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         taps_q      <= '0;
         pixels_q    <= '0;
         filters_q   <= '0;
         tap_cnt_q   <= '0;
         pix_cnt_q   <= '0;
         flt_cnt_q   <= '0;
         total_q     <= '0;
         issued_q    <= '0;
         slot_full_q <= 1'b0;
         act_q       <= '0;
         wgt_q       <= '0;
         bias_q      <= '0;
         bias_vld_q  <= 1'b0;
         fin_q       <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         shift_q     <= '0;
      end else begin
         fin_q  <= 1'b0;
         done_q <= 1'b0;

         if (load) begin
            act_q       <= bus.act_dat;
            wgt_q       <= bus.wgt_dat;
            slot_full_q <= 1'b1;
            issued_q    <= issued_q + TW'(1);
         end else if (xfer) begin
            slot_full_q <= 1'b0;
         end

         if (xfer) begin
            if (last_tap) begin
               tap_cnt_q <= '0;
               pix_cnt_q <= last_pix ? '0 : pix_cnt_q + CNT_W'(1);
            end else begin
               tap_cnt_q <= tap_cnt_q + CNT_W'(1);
            end
         end

         case (state_q)
            S_IDLE: begin
               if (cfg_start) begin
                  taps_q    <= cfg_taps;
                  pixels_q  <= cfg_pixels;
                  filters_q <= cfg_filters;
                  shift_q   <= cfg_shift;
                  total_q   <= {{CNT_W{1'b0}}, cfg_taps} * {{CNT_W{1'b0}}, cfg_pixels};
                  flt_cnt_q <= '0;
                  busy_q    <= 1'b1;
                  if (cfg_zero) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_BIAS;
                  end
               end
            end
            S_BIAS: begin
               if (bus.bin_vld) begin
                  bias_q     <= bus.bin_dat;
                  bias_vld_q <= 1'b1;
                  issued_q   <= '0;
                  tap_cnt_q  <= '0;
                  pix_cnt_q  <= '0;
                  state_q    <= S_STREAM;
               end
            end
            S_STREAM: begin
               if (xfer && last_tap && last_pix) begin
                  state_q <= S_FIN;
                  fin_q   <= 1'b1;
               end
            end
            S_FIN: state_q <= S_WAIT;
            S_WAIT: begin
               if (bus.filter_finish_cal) begin
                  flt_cnt_q <= flt_cnt_q + CNT_W'(1);
                  if (last_flt) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q    <= S_BIAS;
                     bias_vld_q <= 1'b0;
                  end
               end
            end
            S_DONE: begin
               state_q    <= S_IDLE;
               busy_q     <= 1'b0;
               bias_vld_q <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bfp_krnl_feeder.sv
// Randomised bench for bfp_krnl_feeder: stream sources push expected pairs into a
// scoreboard queue, a monitor pops them on every kernel transfer.
module tb_bfp_krnl_feeder;
   localparam int PC    = 64;
   localparam int IDW   = 8;
   localparam int CNT_W = 16;
   localparam int DW    = PC * IDW;

   typedef struct packed {
      logic [DW-1:0] a;
      logic [DW-1:0] w;
   } pair_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             cfg_start;
   logic [CNT_W-1:0] cfg_taps, cfg_pixels, cfg_filters;
   logic [4:0]       cfg_shift;
   logic [4:0]       shift_bits;
   logic             busy, done;

   bfp_krnl_feeder_if #(.PC(PC), .IN_DATA_WIDTH(IDW)) bus ();

   bfp_krnl_feeder #(.PC(PC), .IN_DATA_WIDTH(IDW), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_taps(cfg_taps),
      .cfg_pixels(cfg_pixels), .cfg_filters(cfg_filters), .cfg_shift(cfg_shift),
      .shift_bits(shift_bits), .busy(busy), .done(done), .bus(bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0, cyc = 0;
   // reference model of the running job
   int m_taps, m_pix, m_flt, m_per, m_k;
   logic [31:0] m_bias [8];
   logic [4:0]  exp_shift;
   pair_t exp_q [$];
   int fin_cnt, done_cnt, pop_cnt, bin_pops, first_x, last_x, done_cyc, cal_cyc, start_cyc, cal_real;
   bit fin_next, gap, mon_en, prev_stall;
   logic [DW-1:0] prev_a, prev_w;
   // stimulus knobs
   int act_pct = 100, wgt_pct = 100, rdy_mode = 0, cal_delay = 0, bias_idx = 0, cal_wait = 0;
   bit stray_en = 0, bin_en = 0, wgt_hold0 = 0, cal_pending = 0;

   task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] rnd_vec();
      logic [DW-1:0] v;
      for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // activation / weight / bias sources and kernel ready
   initial begin
      logic [DW-1:0] cur_a, cur_w;
      bit ap;
      bus.act_vld = 0; bus.wgt_vld = 0; bus.bin_vld = 0; bus.up_rdy = 0;
      cur_a = rnd_vec(); cur_w = rnd_vec();
      bus.act_dat = cur_a; bus.wgt_dat = cur_w; bus.bin_dat = '0;
      forever begin
         @(negedge clk);
         ap = bus.act_vld && bus.act_rdy;
         if (ap) begin
            exp_q.push_back('{a: cur_a, w: cur_w});
            pop_cnt++;
         end
         if (bus.bin_vld && bus.bin_rdy) begin
            bias_idx++;
            bin_pops++;
         end
         @(posedge clk);
         #1;
         if (ap || !bus.act_vld) begin
            bus.act_vld = ($urandom_range(1, 100) <= act_pct);
            cur_a = rnd_vec();
            bus.act_dat = cur_a;
         end
         if (ap || !bus.wgt_vld) begin
            bus.wgt_vld = ($urandom_range(1, 100) <= wgt_pct);
            cur_w = rnd_vec();
            bus.wgt_dat = cur_w;
         end
         if (wgt_hold0) bus.wgt_vld = 0;
         case (rdy_mode)
            0:       bus.up_rdy = 1;
            1:       bus.up_rdy = ~bus.up_rdy;
            default: bus.up_rdy = $urandom_range(0, 1);
         endcase
         bus.bin_vld = bin_en;
         bus.bin_dat = m_bias[bias_idx % 8];
      end
   end

   // kernel: acknowledges each filter cal_delay cycles after filter_finish_data,
   // optionally injecting stray pulses while no filter is waiting
   initial begin
      bus.filter_finish_cal = 0;
      forever begin
         @(posedge clk);
         #1;
         bus.filter_finish_cal = 0;
         if (cal_pending) begin
            if (cal_wait == 0) begin
               bus.filter_finish_cal = 1;
               cal_pending = 0;
               cal_real++;
               cal_cyc = cyc;
            end else begin
               cal_wait--;
            end
         end else if (stray_en && !gap && $urandom_range(0, 7) == 0) begin
            bus.filter_finish_cal = 1;
         end
      end
   end

   // monitor / scoreboard
   initial begin
      pair_t e;
      forever begin
         @(negedge clk);
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (mon_en) begin
            chk("coef_vld_eq_up_vld", bus.coef_vld, bus.up_vld);
            chk("act_rdy_eq_wgt_rdy", bus.act_rdy, bus.wgt_rdy);
            if (bus.act_rdy) chk("pop_needs_both_vld", bus.act_vld & bus.wgt_vld, 1);
            if (prev_stall) begin
               chk("stall_up_dat", bus.up_dat, prev_a);
               chk("stall_coef", bus.coef, prev_w);
            end
            if (gap) chk("no_up_vld_in_wait", bus.up_vld, 0);
            chk("filter_finish_data", bus.filter_finish_data, fin_next);
            fin_next = 0;
            if (bus.filter_finish_data) begin
               fin_cnt++;
               gap = 1;
               cal_pending = 1;
               cal_wait = cal_delay;
            end
            if (bus.bin_vld && bus.bin_rdy) begin
               chk("bias_vld_low_in_bias", bus.bias_vld, 0);
               gap = 0;
            end
            if (bus.up_vld && bus.up_rdy) begin
               if (exp_q.size() == 0 || m_per == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL unexpected_xfer: got up_dat %0h expected no transfer", bus.up_dat);
               end else begin
                  e = exp_q.pop_front();
                  chk("up_dat", bus.up_dat, e.a);
                  chk("coef", bus.coef, e.w);
                  chk("acc_result_vld", bus.acc_result_vld, (m_k % m_taps) == m_taps - 1);
                  chk("bias_dat", bus.bias_dat, m_bias[(m_k / m_per) % 8]);
                  chk("bias_vld", bus.bias_vld, 1);
                  if (m_k == 0) first_x = cyc;
                  last_x = cyc;
                  m_k++;
                  if (m_k % m_per == 0) fin_next = 1;
               end
            end
            prev_stall = bus.up_vld && !bus.up_rdy;
            prev_a = bus.up_dat;
            prev_w = bus.coef;
         end
      end
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_up_vld"}, bus.up_vld, 0);
      chk({tag, "_coef_vld"}, bus.coef_vld, 0);
      chk({tag, "_up_dat"}, bus.up_dat, 0);
      chk({tag, "_coef"}, bus.coef, 0);
      chk({tag, "_act_rdy"}, bus.act_rdy, 0);
      chk({tag, "_wgt_rdy"}, bus.wgt_rdy, 0);
      chk({tag, "_bin_rdy"}, bus.bin_rdy, 0);
      chk({tag, "_acc_result_vld"}, bus.acc_result_vld, 0);
      chk({tag, "_filter_finish_data"}, bus.filter_finish_data, 0);
      chk({tag, "_bias_vld"}, bus.bias_vld, 0);
      chk({tag, "_bias_dat"}, bus.bias_dat, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_shift_bits"}, shift_bits, 0);
   endtask

   task automatic start_job(input int t, input int p, input int f, input int cd);
      m_taps = t; m_pix = p; m_flt = f; m_per = t * p; m_k = 0;
      fin_cnt = 0; done_cnt = 0; pop_cnt = 0; bin_pops = 0; cal_real = 0;
      fin_next = 0; gap = 0; prev_stall = 0; cal_pending = 0; cal_delay = cd;
      bias_idx = 0; first_x = 0; last_x = 0; done_cyc = 0; cal_cyc = 0;
      exp_q.delete();
      @(posedge clk);
      #1;
      cfg_taps = CNT_W'(t); cfg_pixels = CNT_W'(p); cfg_filters = CNT_W'(f);
      exp_shift = 5'($urandom_range(0, 31));
      cfg_shift = exp_shift;
      cfg_start = 1; bin_en = 1; mon_en = 1; start_cyc = cyc;
      @(posedge clk);
      #1;
      // latched config must ignore later changes
      cfg_start = 0;
      cfg_taps = CNT_W'($urandom_range(1, 7));
      cfg_pixels = CNT_W'($urandom_range(1, 7));
      cfg_filters = CNT_W'($urandom_range(1, 7));
      cfg_shift = ~exp_shift;
   endtask

   task automatic wait_job(input bit pulse_start);
      int c;
      c = 0;
      while (done_cnt == 0 && c < 3000) begin
         @(posedge clk);
         #1;
         c++;
         cfg_start = (pulse_start && c == 4);
      end
      cfg_start = 0;
      chk("done_within_budget", done_cnt != 0, 1);
      repeat (3) @(negedge clk);
      chk("done_count", done_cnt, 1);
      chk("fin_count", fin_cnt, (m_per != 0) ? m_flt : 0);
      chk("xfer_count", m_k, m_per * m_flt);
      chk("pop_count", pop_cnt, m_per * m_flt);
      chk("bin_pop_count", bin_pops, (m_per != 0) ? m_flt : 0);
      chk("scoreboard_empty", exp_q.size(), 0);
      chk("busy_after_done", busy, 0);
      chk("bias_vld_idle", bus.bias_vld, 0);
      chk("shift_bits", shift_bits, exp_shift);
      if (m_per != 0) begin
         chk("cal_count", cal_real, m_flt);
         chk("done_after_cal", done_cyc, cal_cyc + 1);
      end
      bin_en = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test, required end before 500000");
      $fatal(1);
   end

   initial begin
      int c;
      rst = 1; cfg_start = 0; cfg_taps = '0; cfg_pixels = '0; cfg_filters = '0; cfg_shift = '0;
      mon_en = 0;
      for (int i = 0; i < 8; i++) m_bias[i] = $urandom;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      #2 rst = 0;

      // back-to-back job, acc on transfers 3 and 6, start while busy ignored
      act_pct = 100; wgt_pct = 100; rdy_mode = 0; stray_en = 0;
      start_job(3, 2, 1, 2);
      wait_job(1);
      chk("back_to_back_span", last_x - first_x, 5);

      // stalls with toggling ready and gappy streams, stray cal pulses
      act_pct = 60; wgt_pct = 80; rdy_mode = 1; stray_en = 1;
      start_job(4, 3, 1, 2);
      wait_job(0);

      // three filters with distinct biases and slow kernel acknowledgement
      m_bias[0] = 32'h11; m_bias[1] = 32'h22; m_bias[2] = 32'h33;
      act_pct = 90; wgt_pct = 90; rdy_mode = 2; stray_en = 0;
      start_job(2, 3, 3, 20);
      wait_job(0);

      // zero pixels: immediate done, nothing popped
      start_job(3, 0, 2, 0);
      wait_job(0);
      chk("zero_cfg_done_latency", (done_cyc - start_cyc) <= 2, 1);

      // reset in the middle of streaming
      act_pct = 100; wgt_pct = 100; rdy_mode = 2;
      start_job(4, 4, 2, 3);
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!bus.up_vld && c < 50);
      chk("up_vld_before_reset", bus.up_vld, 1);
      #2;
      mon_en = 0;
      rst = 1;
      #1;
      chk_all_zero("midjob_reset");
      exp_q.delete(); cal_pending = 0; bin_en = 0; done_cnt = 0;
      repeat (2) @(posedge clk);
      #2 rst = 0;
      repeat (6) @(negedge clk);
      chk("no_done_after_reset", done_cnt, 0);
      chk("busy_after_reset", busy, 0);
      start_job(2, 2, 2, 1);
      wait_job(0);

      // weights withheld: no partial pop, nothing presented
      rdy_mode = 0; wgt_hold0 = 1;
      start_job(2, 2, 1, 1);
      repeat (4) @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("act_rdy_without_wgt", bus.act_rdy, 0);
         chk("up_vld_without_wgt", bus.up_vld, 0);
      end
      wgt_hold0 = 0;
      wait_job(0);

      // randomised jobs including single-tap
      for (int j = 0; j < 5; j++) begin
         for (int i = 0; i < 8; i++) m_bias[i] = $urandom;
         act_pct = $urandom_range(50, 100);
         wgt_pct = $urandom_range(50, 100);
         rdy_mode = $urandom_range(0, 2);
         stray_en = $urandom_range(0, 1);
         start_job((j == 0) ? 1 : $urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 3),
                   $urandom_range(0, 5));
         wait_job(j[0]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
